// File: rtl/backbone_pkg.sv
// rtl/backbone_pkg.sv - shared widths, sequencer state enum, tile-command struct and helpers
package backbone_pkg;

    localparam int DATA_W    = 8;
    localparam int ACC_W     = 32;
    localparam int CMD_IDX_W = 16;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_ISSUE,
        SEQ_DRAIN,
        SEQ_DONE
    } seq_state_e;

    typedef struct packed {
        logic [CMD_IDX_W-1:0] m_base;
        logic [CMD_IDX_W-1:0] n_base;
        logic [CMD_IDX_W-1:0] k_base;
        logic [CMD_IDX_W-1:0] m_len;
        logic [CMD_IDX_W-1:0] n_len;
        logic [CMD_IDX_W-1:0] k_len;
        logic                 acc_clear;
        logic                 acc_last;
    } tile_cmd_t;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/gemm_tile_counter.sv
// rtl/gemm_tile_counter.sv - m/n/k tile index nest, k innermost then n then m
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_clear             return all indices to zero
//   i_advance           step to the next tile (wraps to zero after the last)
//   o_m_idx/o_n_idx/o_k_idx  current tile indices
//   o_k_first, o_k_last k index at 0 / at KT-1
//   o_last              current tile is the final tile of the job
module gemm_tile_counter #(
    parameter int MT = 2,
    parameter int NT = 2,
    parameter int KT = 3,
    parameter int W  = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clear,
    input  logic         i_advance,
    output logic [W-1:0] o_m_idx,
    output logic [W-1:0] o_n_idx,
    output logic [W-1:0] o_k_idx,
    output logic         o_k_first,
    output logic         o_k_last,
    output logic         o_last
);

    logic [W-1:0] r_m;
    logic [W-1:0] r_n;
    logic [W-1:0] r_k;
    logic         w_k_wrap;
    logic         w_n_wrap;
    logic         w_m_wrap;

    assign w_k_wrap = (r_k == W'(KT - 1));
    assign w_n_wrap = (r_n == W'(NT - 1));
    assign w_m_wrap = (r_m == W'(MT - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_m <= '0;
            r_n <= '0;
            r_k <= '0;
        end else if (i_clear) begin
            r_m <= '0;
            r_n <= '0;
            r_k <= '0;
        end else if (i_advance) begin
            if (!w_k_wrap) begin
                r_k <= r_k + W'(1);
            end else begin
                r_k <= '0;
                if (!w_n_wrap) begin
                    r_n <= r_n + W'(1);
                end else begin
                    r_n <= '0;
                    r_m <= w_m_wrap ? '0 : r_m + W'(1);
                end
            end
        end
    end

    assign o_m_idx   = r_m;
    assign o_n_idx   = r_n;
    assign o_k_idx   = r_k;
    assign o_k_first = (r_k == '0);
    assign o_k_last  = w_k_wrap;
    assign o_last    = w_k_wrap & w_n_wrap & w_m_wrap;

endmodule

// File: rtl/gemm_tile_sequencer.sv
// rtl/gemm_tile_sequencer.sv - issues GEMM tile commands to a systolic array with outstanding-tile flow control
// Ports:
//   i_clk, i_rst                    clock, asynchronous active-high reset
//   i_start                         begin a job (accepted only when idle)
//   o_busy, o_done, o_err           job active, one-cycle completion pulse, sticky protocol error
//   o_cmd_valid / i_cmd_ready       tile command handshake
//   o_cmd_{m,n,k}_base, _len        tile origin and valid extent (zero when o_cmd_valid is low)
//   o_cmd_acc_clear, o_cmd_acc_last first / last K tile of an output block
//   i_tile_done                     one pulse per completed command, in issue order
//   o_perf_cycles, o_perf_stall     only with GEMM_SEQ_PERF_EN: busy cycles, stalled-command cycles
module gemm_tile_sequencer
    import backbone_pkg::*;
#(
    parameter int  ROWS            = 4,
    parameter int  COLS            = 4,
    parameter int  K_TILE          = 4,
    parameter int  M_TOTAL         = 8,
    parameter int  N_TOTAL         = 8,
    parameter int  K_TOTAL         = 12,
    parameter int  MAX_OUTSTANDING = 2,
    localparam int IDX_W           = $clog2(max_int(M_TOTAL, max_int(N_TOTAL, K_TOTAL)) + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err,
    output logic             o_cmd_valid,
    input  logic             i_cmd_ready,
    output logic [IDX_W-1:0] o_cmd_m_base,
    output logic [IDX_W-1:0] o_cmd_n_base,
    output logic [IDX_W-1:0] o_cmd_k_base,
    output logic [IDX_W-1:0] o_cmd_m_len,
    output logic [IDX_W-1:0] o_cmd_n_len,
    output logic [IDX_W-1:0] o_cmd_k_len,
    output logic             o_cmd_acc_clear,
    output logic             o_cmd_acc_last,
`ifdef GEMM_SEQ_PERF_EN
    output logic [31:0]      o_perf_cycles,
    output logic [31:0]      o_perf_stall,
`endif
    input  logic             i_tile_done
);

    localparam int MT = ceil_div(M_TOTAL, ROWS);
    localparam int NT = ceil_div(N_TOTAL, COLS);
    localparam int KT = ceil_div(K_TOTAL, K_TILE);

    seq_state_e       r_state;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic             r_cmd_valid;
    logic [2:0]       r_out;
    logic [2:0]       w_out_next;
    logic             w_xfer;
    logic             w_td_ok;
    logic             w_td_err;
    logic             w_start_acc;
    logic [IDX_W-1:0] w_m_idx;
    logic [IDX_W-1:0] w_n_idx;
    logic [IDX_W-1:0] w_k_idx;
    logic             w_k_first;
    logic             w_k_last;
    logic             w_last;

    assign w_xfer      = r_cmd_valid & i_cmd_ready;
    assign w_td_ok     = i_tile_done & (r_out != 3'd0);
    assign w_td_err    = i_tile_done & (r_out == 3'd0);
    assign w_out_next  = r_out + {2'b00, w_xfer} - {2'b00, w_td_ok};
    assign w_start_acc = i_start & (r_state == SEQ_IDLE);

    gemm_tile_counter #(
        .MT (MT),
        .NT (NT),
        .KT (KT),
        .W  (IDX_W)
    ) u_counter (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clear   (w_start_acc),
        .i_advance (w_xfer),
        .o_m_idx   (w_m_idx),
        .o_n_idx   (w_n_idx),
        .o_k_idx   (w_k_idx),
        .o_k_first (w_k_first),
        .o_k_last  (w_k_last),
        .o_last    (w_last)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= SEQ_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_cmd_valid <= 1'b0;
            r_out       <= 3'd0;
        end else begin
            r_out  <= w_out_next;
            // a tile_done arriving in the same cycle as an accepted start still flags
            r_err  <= w_td_err | (r_err & ~w_start_acc);
            r_done <= 1'b0;
            case (r_state)
                SEQ_IDLE: begin
                    if (w_start_acc) begin
                        r_state     <= SEQ_ISSUE;
                        r_busy      <= 1'b1;
                        r_cmd_valid <= 1'b1;
                    end
                end
                SEQ_ISSUE: begin
                    if (w_xfer && w_last) begin
                        r_state     <= SEQ_DRAIN;
                        r_cmd_valid <= 1'b0;
                    end else begin
                        // the command stays held while stalled since the count cannot grow without a transfer
                        r_cmd_valid <= (w_out_next < 3'(MAX_OUTSTANDING));
                    end
                end
                SEQ_DRAIN: begin
                    if (w_out_next == 3'd0) begin
                        r_state <= SEQ_DONE;
                        r_done  <= 1'b1;
                    end
                end
                SEQ_DONE: begin
                    r_state <= SEQ_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= SEQ_IDLE;
            endcase
        end
    end

    // command fields come straight from the index registers, so they only move on a transfer
    assign o_cmd_m_base    = r_cmd_valid ? IDX_W'(int'(w_m_idx) * ROWS) : '0;
    assign o_cmd_n_base    = r_cmd_valid ? IDX_W'(int'(w_n_idx) * COLS) : '0;
    assign o_cmd_k_base    = r_cmd_valid ? IDX_W'(int'(w_k_idx) * K_TILE) : '0;
    assign o_cmd_m_len     = r_cmd_valid ? IDX_W'(min_int(ROWS, M_TOTAL - int'(w_m_idx) * ROWS)) : '0;
    assign o_cmd_n_len     = r_cmd_valid ? IDX_W'(min_int(COLS, N_TOTAL - int'(w_n_idx) * COLS)) : '0;
    assign o_cmd_k_len     = r_cmd_valid ? IDX_W'(min_int(K_TILE, K_TOTAL - int'(w_k_idx) * K_TILE)) : '0;
    assign o_cmd_acc_clear = r_cmd_valid & w_k_first;
    assign o_cmd_acc_last  = r_cmd_valid & w_k_last;
    assign o_cmd_valid     = r_cmd_valid;
    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_err           = r_err;

`ifdef GEMM_SEQ_PERF_EN
    logic [31:0] r_perf_cycles;
    logic [31:0] r_perf_stall;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_perf_cycles <= '0;
            r_perf_stall  <= '0;
        end else if (w_start_acc) begin
            r_perf_cycles <= '0;
            r_perf_stall  <= '0;
        end else begin
            if (r_busy && (r_perf_cycles != '1)) begin
                r_perf_cycles <= r_perf_cycles + 32'd1;
            end
            if (r_cmd_valid && !i_cmd_ready && (r_perf_stall != '1)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign o_perf_cycles = r_perf_cycles;
    assign o_perf_stall  = r_perf_stall;
`endif

endmodule

// File: doc/gemm_tile_sequencer.md
GEMM_TILE_SEQUENCER -- requirements
Module: gemm_tile_sequencer

Interface
REQ-001 SHALL have parameter ROWS, default 4, systolic array rows (M tile height).
REQ-002 SHALL have parameter COLS, default 4, systolic array cols (N tile width).
REQ-003 SHALL have parameter K_TILE, default 4, K depth per tile.
REQ-004 SHALL have parameters M_TOTAL=8, N_TOTAL=8, K_TOTAL=12, full GEMM dims.
REQ-005 SHALL have parameter MAX_OUTSTANDING, default 2, issued-but-not-done tile limit (1..4).
REQ-006 SHALL have ports: clk input 1 clock; rst input 1 asynchronous active-high reset.
REQ-007 SHALL have ports: start input 1 begin job; busy output 1 job active; done output 1 one-cycle completion pulse; err output 1 sticky protocol error.
REQ-008 SHALL have ports: cmd_valid output 1; cmd_ready input 1; cmd_m_base, cmd_n_base, cmd_k_base output IDX_W tile origin; cmd_m_len, cmd_n_len, cmd_k_len output IDX_W valid extent; cmd_acc_clear output 1 first K tile; cmd_acc_last output 1 last K tile (writeback).
REQ-009 SHALL have port tile_done input 1, one pulse per completed command, in issue order.

Function
REQ-010 SHALL compute MT=ceil(M_TOTAL/ROWS), NT=ceil(N_TOTAL/COLS), KT=ceil(K_TOTAL/K_TILE), total tiles MT*NT*KT.
REQ-011 SHALL issue tiles in order k innermost, then n, then m; bases = index*ROWS/COLS/K_TILE.
REQ-012 SHALL set each len = min(tile size, TOTAL - base) (edge tiles shorter).
REQ-013 SHALL assert cmd_acc_clear when k index = 0 and cmd_acc_last when k index = KT-1; both when KT=1.
REQ-014 SHALL use FSM IDLE -> ISSUE (start) -> DRAIN (last tile accepted) -> DONE (outstanding=0) -> IDLE.
REQ-015 SHALL transfer a command on cmd_valid & cmd_ready; cmd fields held stable while cmd_valid & !cmd_ready.
REQ-016 SHALL deassert cmd_valid when outstanding = MAX_OUTSTANDING; first cmd_valid the cycle after start accepted.
REQ-017 SHALL handle transfer and tile_done in same cycle: outstanding unchanged.
REQ-018 SHALL assert busy from cycle after start through DONE; done high exactly one cycle in DONE.
REQ-019 SHALL ignore start while busy; SHALL ignore start in DONE cycle.
REQ-020 SHALL set err on tile_done with outstanding = 0 and not decrement below 0; err cleared only by reset or next accepted start.

Reset
REQ-021 SHALL on rst asynchronously force IDLE, counters 0, outstanding 0; busy, done, err, cmd_valid, cmd_acc_clear, cmd_acc_last = 0; cmd bases/lens = 0.
REQ-022 SHALL on rst mid-job abandon the job with no done pulse; tile_done pulses after reset release are errors only if outstanding = 0 (REQ-020).

Configuration
REQ-023 SHALL with GEMM_SEQ_PERF_EN defined add outputs perf_cycles (32) counting busy cycles and perf_stall (32) counting cycles cmd_valid & !cmd_ready, both cleared on accepted start, saturating at max.
REQ-024 SHALL without GEMM_SEQ_PERF_EN omit those ports and counters entirely.

Structure
REQ-025 SHALL place DATA_W, ACC_W, seq state enum and a tile-command struct typedef in backbone_pkg; IDX_W = $clog2(max totals + 1) local.
REQ-026 SHALL implement the m/n/k index nest as one sub-module gemm_tile_counter (advance, wrap flags, first/last flags).

Verification
REQ-027 SHALL cover 8x8x12, 4/4/4, cmd_ready=1, tile_done 3 cycles after each accept -> 12 cmds; #0 (0,0,0) clear=1 last=0; #2 k_base=8 last=1; #3 (0,4,0) clear=1; done one pulse after 12th tile_done.
REQ-028 SHALL cover M_TOTAL=6 -> cmds with m_base=4 have m_len=2; K_TOTAL=10 -> k_base=8 has k_len=2.
REQ-029 SHALL cover cmd_ready low 5 cycles on cmd #1 -> fields stable, perf_stall=5 (macro on), no skipped/duplicate tile.
REQ-030 SHALL cover tile_done withheld -> exactly MAX_OUTSTANDING=2 accepts then cmd_valid=0 until tile_done; simultaneous accept+tile_done keeps outstanding 2.
REQ-031 SHALL cover rst pulse after 5 accepts -> all outputs 0 next cycle, no done; new start reissues from (0,0,0).
REQ-032 SHALL cover tile_done while idle -> err=1 held; start while busy -> ignored, tile count unchanged.
